// File: rtl/m3_keycmddecode.sv
`default_nettype none
// =============================================================================
// Module   : m3_keycmddecode
// Summary  : Debounced push-button front end and IDLE/RUN/STOP run-state machine
//            feeding m3_powerAndSpeedCalc. Define M3_KEY_AUTOREPEAT_EN to add
//            auto-repeat on the speed/power adjust keys.
// Revision : 1.0  initial release
// =============================================================================
module m3_keycmddecode #(
  parameter int DEBOUNCE_CYC   = 20000,
  parameter int STOP_HOLD_CYC  = 1000,
  parameter int REPEAT_DLY_CYC = 500000,
  parameter int REPEAT_PER_CYC = 100000
) (
  input  logic clkI,
  input  logic rstI,
  input  logic keyStartN,
  input  logic keyStopN,
  input  logic keyInvN,
  input  logic keySpdIncN,
  input  logic keySpdDecN,
  input  logic keyPwrIncN,
  input  logic keyPwrDecN,
  output logic m3startO,
  output logic m3forceStopO,
  output logic m3invRotateO,
  output logic m3speedINCo,
  output logic m3speedDECo,
  output logic m3powerINCo,
  output logic m3powerDECo,
  output logic runningO
);

  localparam int NKEY      = 7;
  localparam int K_START   = 0;
  localparam int K_STOP    = 1;
  localparam int K_INV     = 2;
  localparam int K_SPD_INC = 3;
  localparam int K_PWR_DEC = 6;

  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HOLD_W = (STOP_HOLD_CYC > 1) ? $clog2(STOP_HOLD_CYC) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STOP_HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  logic [NKEY-1:0]   raw_n;
  logic [NKEY-1:0]   press_evt;
  logic [3:0]        adj_level;
  logic [3:0]        adj_evt;     // {pwr_dec, pwr_inc, spd_dec, spd_inc}
  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              start_q, start_nxt;
  logic              force_q, force_nxt;
  logic              inv_q, inv_nxt;
  logic              running_q;
  logic [3:0]        adj_q, adj_nxt;

  assign raw_n = {keyPwrDecN, keyPwrIncN, keySpdDecN, keySpdIncN,
                  keyInvN, keyStopN, keyStartN};

  // Per key: 2-flop synchroniser, then a saturating agreement counter.
  for (genvar k = 0; k < NKEY; k++) begin : g_key
    logic            sync_a, sync_b, level;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clkI or posedge rstI) begin
      if (rstI) begin
        sync_a <= 1'b1;
        sync_b <= 1'b1;
        level  <= 1'b0;
        cnt    <= '0;
      end else begin
        sync_a <= raw_n[k];
        sync_b <= sync_a;
        if (~sync_b == level) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          level <= ~sync_b;
          cnt   <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end
    end

    // Fires in the cycle before the debounced level rises, so the registered
    // command lands DEBOUNCE_CYC+2 cycles after the raw press.
    assign press_evt[k] = ~sync_b & ~level & (cnt == DB_LAST);

    if (k >= K_SPD_INC) begin : g_adj_level
      assign adj_level[k-K_SPD_INC] = level;
    end
  end

`ifdef M3_KEY_AUTOREPEAT_EN
  localparam int RP_MAX = (REPEAT_DLY_CYC > REPEAT_PER_CYC) ? REPEAT_DLY_CYC : REPEAT_PER_CYC;
  localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
  localparam logic [RP_W-1:0] DLY_LAST = RP_W'(REPEAT_DLY_CYC - 1);
  localparam logic [RP_W-1:0] PER_LAST = RP_W'(REPEAT_PER_CYC - 1);

  logic [3:0] rep_evt;

  // First repeat after the initial delay, then one per period while held in RUN.
  for (genvar j = 0; j < 4; j++) begin : g_repeat
    logic            active, repeating;
    logic [RP_W-1:0] hold;

    assign active     = adj_level[j] & (state == RUN);
    assign rep_evt[j] = active & (hold == (repeating ? PER_LAST : DLY_LAST));

    always_ff @(posedge clkI or posedge rstI) begin
      if (rstI) begin
        hold      <= '0;
        repeating <= 1'b0;
      end else if (!active) begin
        hold      <= '0;
        repeating <= 1'b0;
      end else if (rep_evt[j]) begin
        hold      <= '0;
        repeating <= 1'b1;
      end else begin
        hold <= hold + RP_W'(1);
      end
    end
  end

  assign adj_evt = press_evt[K_PWR_DEC:K_SPD_INC] | rep_evt;
`else
  // Repeat timing has no hardware in this build; the empty block keeps the
  // parameters referenced.
  if (REPEAT_DLY_CYC < 1 || REPEAT_PER_CYC < 1) begin : g_repeat_off
  end

  assign adj_evt = press_evt[K_PWR_DEC:K_SPD_INC] & {4{|adj_level | 1'b1}};
`endif

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    start_nxt = 1'b0;
    inv_nxt   = inv_q;
    adj_nxt   = 4'b0000;
    case (state)
      IDLE: begin
        if (press_evt[K_STOP]) begin
          state_nxt = STOP;
          hold_nxt  = HOLD_LAST;
        end else if (press_evt[K_START]) begin
          state_nxt = RUN;
          start_nxt = 1'b1;
        end
        if (press_evt[K_INV]) begin
          inv_nxt = ~inv_q;
        end
      end
      RUN: begin
        if (press_evt[K_STOP]) begin
          state_nxt = STOP;
          hold_nxt  = HOLD_LAST;
        end
        // An INC and a DEC of the same kind in one cycle cancel out.
        adj_nxt[0] = adj_evt[0] & ~adj_evt[1];
        adj_nxt[1] = adj_evt[1] & ~adj_evt[0];
        adj_nxt[2] = adj_evt[2] & ~adj_evt[3];
        adj_nxt[3] = adj_evt[3] & ~adj_evt[2];
      end
      STOP: begin
        if (press_evt[K_STOP]) begin
          hold_nxt = HOLD_LAST;
        end else if (hold_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    force_nxt = (state_nxt == STOP);
  end

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      start_q   <= 1'b0;
      force_q   <= 1'b0;
      inv_q     <= 1'b0;
      adj_q     <= 4'b0000;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      start_q   <= start_nxt;
      force_q   <= force_nxt;
      inv_q     <= inv_nxt;
      adj_q     <= adj_nxt;
      running_q <= (state == RUN);
    end
  end

  assign m3startO     = start_q;
  assign m3forceStopO = force_q;
  assign m3invRotateO = inv_q;
  assign m3speedINCo  = adj_q[0];
  assign m3speedDECo  = adj_q[1];
  assign m3powerINCo  = adj_q[2];
  assign m3powerDECo  = adj_q[3];
  assign runningO     = running_q;

endmodule
`default_nettype wire

// File: tb/tb_m3_keycmddecode.sv
`default_nettype none
// Testbench for m3_keycmddecode: debounce timing, run-state machine, direction,
// adjust pulses, auto-repeat and asynchronous reset against hand-computed values.
module tb_m3_keycmddecode;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int RDLY = 16;
  localparam int RPER = 8;
  localparam int ROW_HOLD = 10;
  localparam int ROW_CYC  = 30;

  localparam logic [6:0] P_NONE  = 7'b0000000;
  localparam logic [6:0] P_START = 7'b0000001;
  localparam logic [6:0] P_STOP  = 7'b0000010;
  localparam logic [6:0] P_INV   = 7'b0000100;
  localparam logic [6:0] P_SI    = 7'b0001000;
  localparam logic [6:0] P_SD    = 7'b0010000;
  localparam logic [6:0] P_PI    = 7'b0100000;
  localparam logic [6:0] P_PD    = 7'b1000000;

  typedef struct {
    string      name;
    logic [6:0] press;
    int         st, fs, si, sd, pi, pd;
    logic       inv, run;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] keys_n = 7'h7F;
  logic start_o, force_o, inv_o, si_o, sd_o, pi_o, pd_o, run_o;

  int   passed = 0;
  int   total  = 0;
  vec_t tbl[$];
  int   rep_q[$];
  int   exp_q[$];

  always #5 clk = ~clk;

  m3_keycmddecode #(
    .DEBOUNCE_CYC  (DEB),
    .STOP_HOLD_CYC (HOLD),
    .REPEAT_DLY_CYC(RDLY),
    .REPEAT_PER_CYC(RPER)
  ) dut (
    .clkI        (clk),
    .rstI        (rst),
    .keyStartN   (keys_n[0]),
    .keyStopN    (keys_n[1]),
    .keyInvN     (keys_n[2]),
    .keySpdIncN  (keys_n[3]),
    .keySpdDecN  (keys_n[4]),
    .keyPwrIncN  (keys_n[5]),
    .keyPwrDecN  (keys_n[6]),
    .m3startO    (start_o),
    .m3forceStopO(force_o),
    .m3invRotateO(inv_o),
    .m3speedINCo (si_o),
    .m3speedDECo (sd_o),
    .m3powerINCo (pi_o),
    .m3powerDECo (pd_o),
    .runningO    (run_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [6:0] press);
    keys_n = ~press;
  endtask

  function automatic logic [7:0] obs();
    return {run_o, pd_o, pi_o, sd_o, si_o, inv_o, force_o, start_o};
  endfunction

  function automatic vec_t mk(input string n, input logic [6:0] p, input int st, input int fs,
                              input int si, input int sd, input int pi, input int pd,
                              input logic inv, input logic run);
    vec_t v;
    v.name = n; v.press = p; v.st = st; v.fs = fs; v.si = si; v.sd = sd;
    v.pi = pi; v.pd = pd; v.inv = inv; v.run = run;
    return v;
  endfunction

  // Press the row's keys for ROW_HOLD cycles, count high cycles on every output.
  task automatic run_row(input vec_t r);
    int st = 0, fs = 0, si = 0, sd = 0, pi = 0, pd = 0;
    set_keys(r.press);
    for (int c = 1; c <= ROW_CYC; c++) begin
      tick();
      if (c == ROW_HOLD) set_keys(P_NONE);
      if (start_o) st++;
      if (force_o) fs++;
      if (si_o) si++;
      if (sd_o) sd++;
      if (pi_o) pi++;
      if (pd_o) pd++;
    end
    check({r.name, ".start"}, st, r.st);
    check({r.name, ".stop"},  fs, r.fs);
    check({r.name, ".spdinc"}, si, r.si);
    check({r.name, ".spddec"}, sd, r.sd);
    check({r.name, ".pwrinc"}, pi, r.pi);
    check({r.name, ".pwrdec"}, pd, r.pd);
    check({r.name, ".inv"}, inv_o, r.inv);
    check({r.name, ".run"}, run_o, r.run);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, rc, fc, first, last;

    //                name            press           st fs si sd pi pd inv   run
    tbl.push_back(mk("start",         P_START,         1, 0, 0, 0, 0, 0, 1'b0, 1'b1));
    tbl.push_back(mk("spd_cancel",    P_SI | P_SD,     0, 0, 0, 0, 0, 0, 1'b0, 1'b1));
    tbl.push_back(mk("pwr_inc",       P_PI,            0, 0, 0, 0, 1, 0, 1'b0, 1'b1));
    tbl.push_back(mk("pwr_dec",       P_PD,            0, 0, 0, 0, 0, 1, 1'b0, 1'b1));
    tbl.push_back(mk("spd_inc",       P_SI,            0, 0, 1, 0, 0, 0, 1'b0, 1'b1));
    tbl.push_back(mk("pwr_cancel",    P_PI | P_PD,     0, 0, 0, 0, 0, 0, 1'b0, 1'b1));
    tbl.push_back(mk("inv_in_run",    P_INV,           0, 0, 0, 0, 0, 0, 1'b0, 1'b1));
    tbl.push_back(mk("start_in_run",  P_START,         0, 0, 0, 0, 0, 0, 1'b0, 1'b1));
    tbl.push_back(mk("stop_run",      P_STOP,          0, 8, 0, 0, 0, 0, 1'b0, 1'b0));
    tbl.push_back(mk("pwr_inc_idle",  P_PI,            0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    tbl.push_back(mk("inv_idle",      P_INV,           0, 0, 0, 0, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mk("start_and_stop", P_START | P_STOP, 0, 8, 0, 0, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mk("start2",        P_START,         1, 0, 0, 0, 0, 0, 1'b1, 1'b1));
    tbl.push_back(mk("inv_in_run2",   P_INV,           0, 0, 0, 0, 0, 0, 1'b1, 1'b1));
    tbl.push_back(mk("spd_pwr_inc",   P_SI | P_PI,     0, 0, 1, 0, 1, 0, 1'b1, 1'b1));
    tbl.push_back(mk("stop2",         P_STOP,          0, 8, 0, 0, 0, 0, 1'b1, 1'b0));
    tbl.push_back(mk("inv_idle2",     P_INV,           0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    tbl.push_back(mk("stop_idle",     P_STOP,          0, 8, 0, 0, 0, 0, 1'b0, 1'b0));
    tbl.push_back(mk("spd_inc_idle",  P_SI,            0, 0, 0, 0, 0, 0, 1'b0, 1'b0));

`ifdef M3_KEY_AUTOREPEAT_EN
    exp_q.push_back(6);
    exp_q.push_back(22);
    exp_q.push_back(30);
    exp_q.push_back(38);
    exp_q.push_back(46);
`else
    exp_q.push_back(6);
`endif

    // Reset state
    rst = 1'b1;
    set_keys(P_NONE);
    repeat (3) tick();
    check("reset_outputs", obs(), 8'h00);
    rst = 1'b0;
    tick();
    check("after_reset", obs(), 8'h00);

    // Bouncing start key: low 2, high 1, low 2, high
    sc = 0; rc = 0;
    for (int c = 0; c < 20; c++) begin
      set_keys((c < 2 || c == 3 || c == 4) ? P_START : P_NONE);
      tick();
      if (start_o) sc++;
      if (run_o) rc++;
    end
    check("bounce_start", sc, 0);
    check("bounce_running", rc, 0);

    // Start latency: pulse exactly at cycle 6, running from cycle 7
    set_keys(P_START);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) check("start_not_early", start_o, 1'b0);
      if (k == 6) begin
        check("start_at_6", start_o, 1'b1);
        check("running_before", run_o, 1'b0);
      end
      if (k == 7) begin
        check("start_one_cycle", start_o, 1'b0);
        check("running_after", run_o, 1'b1);
      end
    end
    set_keys(P_NONE);
    repeat (10) tick();
    check("running_holds", run_o, 1'b1);

    // Stop hold length, with a start press landing inside STOP
    first = -1; last = -1; fc = 0; sc = 0;
    set_keys(P_STOP);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (force_o) begin
        fc++;
        if (first < 0) first = k;
        last = k;
      end
      if (start_o) sc++;
      if (k == 6) check("run_at_stop_edge", run_o, 1'b1);
      if (k == 7) begin
        check("run_drop", run_o, 1'b0);
        set_keys(P_START);
      end
      if (k == 15) set_keys(P_NONE);
    end
    check("stop_first", first, 6);
    check("stop_last", last, 13);
    check("stop_len", fc, HOLD);
    check("start_in_stop", sc, 0);
    check("idle_after_stop", run_o, 1'b0);

    foreach (tbl[i]) run_row(tbl[i]);

    // Held speed-up key in RUN
    run_row(mk("start_rep", P_START, 1, 0, 0, 0, 0, 0, 1'b0, 1'b1));
    set_keys(P_SI);
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k == 44) set_keys(P_NONE);
      if (si_o) rep_q.push_back(k);
    end
    check("rep_count", rep_q.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("rep_pulse%0d", i), (i < rep_q.size()) ? rep_q[i] : -1, exp_q[i]);
    run_row(mk("stop_rep", P_STOP, 0, 8, 0, 0, 0, 0, 1'b0, 1'b0));

    // Asynchronous reset in the middle of the stop hold (hold count 3)
    run_row(mk("inv_pre_reset", P_INV, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0));
    run_row(mk("start_pre_reset", P_START, 1, 0, 0, 0, 0, 0, 1'b1, 1'b1));
    first = -1;
    set_keys(P_STOP);
    for (int k = 1; k <= 20 && first < 0; k++) begin
      tick();
      if (force_o) first = k;
    end
    check("stop_seen", first, 6);
    set_keys(P_NONE);
    repeat (4) tick();
    check("force_before_reset", force_o, 1'b1);
    rst = 1'b1;
    #1;
    check("reset_async_outputs", obs(), 8'h00);
    check("reset_async_inv", inv_o, 1'b0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    check("idle_after_reset", obs(), 8'h00);
    run_row(mk("start_after_reset", P_START, 1, 0, 0, 0, 0, 0, 1'b0, 1'b1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m3_keycmddecode.md
Name: m3_keyCmdDecode

Overview:
- Upstream command stage for m3_powerAndSpeedCalc.
- Takes seven raw active-low push-button inputs.
- Synchronises and debounces each one, then runs a small motor run-state machine.
- Produces the clean one-cycle command pulses and the rotate-direction level that the power/speed calculator consumes (m3startI, m3forceStopI, m3invRotateI, m3speed*/m3power*).

Parameters:
- DEBOUNCE_CYC, 20000: consecutive stable cycles required before a debounced level changes (20 ms at 1 MHz).
- STOP_HOLD_CYC, 1000: cycles m3forceStopO stays high after a stop command.
- REPEAT_DLY_CYC, 500000: hold time before auto-repeat starts (only with the optional feature).
- REPEAT_PER_CYC, 100000: auto-repeat pulse period (only with the optional feature).

Ports:
- clkI  in  1  system clock, 1 MHz
- rstI  in  1  asynchronous reset, active-high
- keyStartN  in  1  raw start button, active-low
- keyStopN  in  1  raw stop button, active-low
- keyInvN  in  1  raw direction-toggle button, active-low
- keySpdIncN  in  1  raw speed-up button, active-low
- keySpdDecN  in  1  raw speed-down button, active-low
- keyPwrIncN  in  1  raw power-up button, active-low
- keyPwrDecN  in  1  raw power-down button, active-low
- m3startO  out  1  one-cycle start pulse
- m3forceStopO  out  1  stop level, held STOP_HOLD_CYC cycles
- m3invRotateO  out  1  direction level, 1 = reverse
- m3speedINCo, m3speedDECo, m3powerINCo, m3powerDECo  out  1 each  one-cycle adjust pulses
- runningO  out  1  high in RUN state

Behaviour:
- Reset (rstI=1, asynchronous):
  - All outputs 0, state IDLE.
  - Synchroniser flops cleared to "released".
  - Debounced levels 0, all counters 0.
- Per key:
  - 2-flop synchroniser, then inversion, so pressed = 1.
  - The debounce counter increments while the synced level differs from the debounced level. It clears to 0 on agreement.
  - When the counter reaches DEBOUNCE_CYC-1, the debounced level takes the synced value and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYC); it never wraps.
- Press event: debounced 0->1 edge, valid for one cycle. Latency from stable raw low to event = 2 + DEBOUNCE_CYC cycles. Releases generate no event.
- State machine, states IDLE / RUN / STOP:
  - IDLE + start event -> RUN; m3startO=1 for that one cycle.
  - RUN + stop event -> STOP; m3forceStopO=1 and hold counter loaded.
  - IDLE + stop event -> STOP as well (a stop always forces a stop hold).
  - STOP: m3forceStopO stays 1 for exactly STOP_HOLD_CYC cycles, then -> IDLE with m3forceStopO=0.
  - Start events in RUN or STOP are ignored.
  - A stop event during STOP reloads the hold counter.
  - Simultaneous start and stop events: stop wins, no m3startO.
- Direction:
  - An inv event in IDLE toggles m3invRotateO on the next edge.
  - Inv events in RUN or STOP are ignored, so the direction never changes while the motor turns.
- Adjust pulses:
  - Speed/power INC/DEC events are forwarded as one-cycle pulses only in RUN; otherwise they are dropped.
  - INC and DEC events of the same kind in the same cycle cancel: neither pulse is issued.
  - Speed and power are independent.
- runningO = (state==RUN), registered.
- All outputs are registered, with no combinational path from key inputs.

Optional Feature:
- Macro: M3_KEY_AUTOREPEAT_EN.
- With the macro defined:
  - Each of the four adjust keys has a hold counter while it is debounced-pressed in RUN.
  - After REPEAT_DLY_CYC cycles of continuous hold, one extra pulse is issued; then one more every REPEAT_PER_CYC cycles until release or leaving RUN.
  - Release or a state change clears the hold counter.
  - INC/DEC cancellation also applies to repeat pulses.
- Without the macro: exactly one pulse per press, no hold counters synthesised, and the REPEAT_* parameters are unused.

Test Plan (DEBOUNCE_CYC=4, STOP_HOLD_CYC=8, REPEAT_DLY_CYC=16, REPEAT_PER_CYC=8):
- Reset, then keyStartN low for 10 cycles -> m3startO high exactly 1 cycle, 6 cycles after the falling edge; runningO=1 next cycle and stays.
- In IDLE, keyStartN bounces (low 2 cycles, high 1, low 2, high) -> no m3startO; state remains IDLE.
- In RUN, keyStopN low 10 cycles -> m3forceStopO high exactly 8 cycles, runningO drops; state IDLE afterwards. keyStartN pressed during STOP -> no m3startO.
- In IDLE, keyInvN pressed -> m3invRotateO 0->1. Pressed again in RUN -> stays 1. Stop and press once more in IDLE -> 0.
- In RUN, keySpdIncN and keySpdDecN pressed in the same cycle -> no speed pulses. keyPwrIncN alone -> one m3powerINCo pulse. The same key in IDLE -> no pulse.
- With M3_KEY_AUTOREPEAT_EN, in RUN, keySpdIncN held 40 cycles after debounce -> pulses at debounce+0, +16, +24, +32, +40, stopping on release. Without the macro -> a single pulse.
- Assert rstI mid-STOP (hold count 3) -> all outputs 0 immediately, state IDLE, m3invRotateO=0.
